// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory slave and its storage array.
package apb_mem_pkg;

    // Transfer FSM: IDLE waits for a setup cycle, ACCESS runs wait states and completion.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Helpers operate on the widest supported data bus; callers zero-extend and truncate.
    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    // Geometry of the default build (32-bit data, 256 words).
    localparam int STRB_WIDTH       = 4;
    localparam int BYTE_OFFSET_BITS = 2;
    localparam int WORD_INDEX_BITS  = 8;

    // Replace the bytes of old_word selected by strb with the matching bytes of new_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_STRB_WIDTH-1:0] strb
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_STRB_WIDTH; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    // True when addr falls inside the window [base, base + span).
    function automatic logic addr_in_range(
        input logic [63:0] addr,
        input logic [63:0] base,
        input logic [63:0] span
    );
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Word storage with a per-word valid bit. Unwritten words read as UNINIT_VALUE,
// and a partial write into an unwritten word fills the unstrobed bytes from UNINIT_VALUE.
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] UNINIT_VALUE = '1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     widx,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic [$clog2(DEPTH)-1:0]     ridx,
    output logic [DATA_WIDTH-1:0]        rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      valid;
    logic [DATA_WIDTH-1:0] wbase;
    logic [DATA_WIDTH-1:0] wmerged;
    logic                  wcommit;

    // An all-zero strobe is a no-op: neither the word nor its valid bit changes.
    assign wcommit = we && !rst && (wstrb != '0);

    // Build the post-write word from the current (or fill) value and the strobed bytes.
    always_comb begin
        wbase   = valid[widx] ? mem[widx] : UNINIT_VALUE;
        wmerged = DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(wbase),
                                          MAX_DATA_WIDTH'(wdata),
                                          MAX_STRB_WIDTH'(wstrb)));
    end

    // Storage itself is never cleared; the valid bits hide stale contents.
    always_ff @(posedge clk) begin
        if (wcommit) begin
            mem[widx] <= wmerged;
        end
    end

    // Valid bits clear on reset and set on any committed write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wcommit) begin
            valid[widx] <= 1'b1;
        end
    end

    // Combinational read port with fill value for never-written words.
    always_comb begin
        rdata = valid[ridx] ? mem[ridx] : UNINIT_VALUE;
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB target memory: setup/access handshake, fixed wait states, byte strobes and
// PSLVERR on misaligned or out-of-window addresses. All APB outputs are registered.
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen in IDLE;
// the request is latched there. The transfer completes in the cycle where
// psel=1, penable=1 and pready=1; prdata/pslverr are meaningful only in that
// cycle and are 0 otherwise. Dropping psel before completion aborts the transfer.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH        = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    WAIT_STATES  = 0,
    parameter logic [DATA_WIDTH-1:0] UNINIT_VALUE = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pready,
    output logic                    pslverr
);

    localparam int          SW       = DATA_WIDTH / 8;
    localparam int          OB       = $clog2(SW);
    localparam int          IB       = $clog2(DEPTH);
    localparam logic [63:0] SPAN     = 64'(DEPTH) * 64'(SW);
    localparam logic [3:0]  WS_LOAD  = 4'(WAIT_STATES);

    state_t                state;
    state_t                state_next;

    // Request latched at the setup cycle.
    logic [IB-1:0]         idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         strb_q;
    logic [3:0]            cnt_q;

    // Decode of the live bus address, used only at the setup cycle.
    logic [IB-1:0]         idx_in;
    logic                  err_in;

    logic                  setup;
    logic                  done;
    logic [IB-1:0]         ridx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Next values of the registered outputs and the write strobe into the array.
    logic                  pready_d;
    logic                  pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_d;
    logic                  mem_we;

    assign setup = (state == IDLE) && psel && !penable;
    assign done  = (state == ACCESS) && psel && penable && pready;

    // Word index relative to the window base, and the error flag for this address.
    always_comb begin
        idx_in = IB'((64'(paddr) - 64'(BASE_ADDR)) >> OB);
        err_in = ((paddr & ADDR_WIDTH'(SW - 1)) != '0) ||
                 !addr_in_range(64'(paddr), 64'(BASE_ADDR), SPAN);
    end

    // In IDLE the read port looks at the live address so zero-wait reads can
    // register their data at the setup edge; in ACCESS it uses the latched index.
    assign ridx = (state == IDLE) ? idx_in : idx_q;

    apb_mem_array #(
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH),
        .UNINIT_VALUE (UNINIT_VALUE)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .ridx  (ridx),
        .rdata (rd_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: enter ACCESS on setup, leave on completion or abort.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel || done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: decide next registered outputs and when to commit a write.
    always_comb begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (setup && (WAIT_STATES == 0)) begin
                    pready_d  = 1'b1;
                    pslverr_d = err_in;
                    prdata_d  = (!pwrite && !err_in) ? rd_word : '0;
                end
            end
            ACCESS: begin
                if (psel) begin
                    if (done) begin
                        mem_we = write_q && !err_q && !rst;
                    end else if (pready) begin
                        // Response already presented; hold it until penable arrives.
                        pready_d  = 1'b1;
                        pslverr_d = pslverr;
                        prdata_d  = prdata;
                    end else if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                        prdata_d  = (!write_q && !err_q) ? rd_word : '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Request latch at setup; bus changes during ACCESS are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (setup) begin
            idx_q   <= idx_in;
            write_q <= pwrite;
            err_q   <= err_in;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
        end
    end

    // Wait counter: loaded at setup, counts down once per ACCESS cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (setup) begin
            cnt_q <= WS_LOAD;
        end else if ((state == ACCESS) && (cnt_q != 4'd0)) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Registered APB response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= pready_d;
            pslverr <= pslverr_d;
            prdata  <= prdata_d;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Bench for apb_mem_slave: two instances (zero and three wait states) driven one
// at a time. Each issued transfer pushes its expected response, computed from a
// word/valid reference model, and a per-instance monitor pops and compares it at
// completion, also checking the completion latency and idle outputs.
module tb_apb_mem_slave;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_s     [2];
    logic        psel_s    [2];
    logic        penable_s [2];
    logic        pwrite_s  [2];
    logic [31:0] paddr_s   [2];
    logic [31:0] pwdata_s  [2];
    logic [3:0]  pstrb_s   [2];
    logic [31:0] prdata_s  [2];
    logic        pready_s  [2];
    logic        pslverr_s [2];

    apb_mem_slave #(.WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .rst(rst_s[0]), .psel(psel_s[0]), .penable(penable_s[0]),
        .pwrite(pwrite_s[0]), .paddr(paddr_s[0]), .pwdata(pwdata_s[0]), .pstrb(pstrb_s[0]),
        .prdata(prdata_s[0]), .pready(pready_s[0]), .pslverr(pslverr_s[0])
    );

    apb_mem_slave #(.WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rst(rst_s[1]), .psel(psel_s[1]), .penable(penable_s[1]),
        .pwrite(pwrite_s[1]), .paddr(paddr_s[1]), .pwdata(pwdata_s[1]), .pstrb(pstrb_s[1]),
        .prdata(prdata_s[1]), .pready(pready_s[1]), .pslverr(pslverr_s[1])
    );

    int n_cmp = 0;
    int n_err = 0;
    bit mon_on = 1'b0;
    int cyc [2];

    // Expected response: {is_read, pslverr, prdata}.
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];

    // Reference model: one word and one written flag per location, per instance.
    logic [31:0] mdl_mem [2][256];
    bit          mdl_val [2][256];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h400);
    endfunction

    task automatic push(input int d, input logic [33:0] e);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic logic [33:0] pop(input int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Monitor step for one instance, evaluated on every falling edge.
    task automatic mon_cycle(input int d);
        logic [33:0] e;
        logic [33:0] g;
        int          ws;
        ws = (d == 0) ? WS0 : WS1;
        if (!mon_on) return;
        if (psel_s[d] && !penable_s[d]) cyc[d] = 0;
        else if (psel_s[d] && penable_s[d]) cyc[d]++;
        if (psel_s[d] && penable_s[d] && pready_s[d]) begin
            if (q_size(d) == 0) begin
                check($sformatf("unexpected_pready_dut%0d", d), 64'(pready_s[d]), 64'd0);
            end else begin
                e = pop(d);
                g = {e[33], pslverr_s[d], (e[33] ? prdata_s[d] : 32'h0)};
                check($sformatf("completion_dut%0d", d), 64'(g), 64'(e));
                check($sformatf("latency_dut%0d", d), 64'(cyc[d]), 64'(1 + ws));
            end
        end else begin
            check($sformatf("idle_outputs_dut%0d", d),
                  64'({pready_s[d], pslverr_s[d], prdata_s[d]}), 64'd0);
        end
    endtask

    always @(negedge clk) mon_cycle(0);
    always @(negedge clk) mon_cycle(1);

    // Drive one transfer and wait (bounded) for completion. Address, data and
    // strobes are scrambled during ACCESS since the slave must use its latched copy.
    task automatic drive(input int d, input logic wr, input logic [31:0] a,
                         input logic [31:0] data, input logic [3:0] strb);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        psel_s[d]    = 1'b1;
        penable_s[d] = 1'b0;
        pwrite_s[d]  = wr;
        paddr_s[d]   = a;
        pwdata_s[d]  = data;
        pstrb_s[d]   = strb;
        @(posedge clk); #1;
        penable_s[d] = 1'b1;
        paddr_s[d]   = $urandom;
        pwdata_s[d]  = $urandom;
        pstrb_s[d]   = 4'($urandom);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pready_s[d]) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_dut%0d: no pready within 40 cycles, expected completion", d);
        end
    endtask

    // Record the expected response in the model, then run the transfer.
    task automatic issue(input int d, input logic wr, input logic [31:0] a,
                         input logic [31:0] data, input logic [3:0] strb);
        logic        bad;
        logic [31:0] word;
        int          w;
        bad = addr_bad(a);
        w   = int'(a[9:2]);
        if (wr) begin
            if (!bad && (strb != 4'h0)) begin
                word = mdl_val[d][w] ? mdl_mem[d][w] : 32'hFFFF_FFFF;
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
                end
                mdl_mem[d][w] = word;
                mdl_val[d][w] = 1'b1;
            end
            push(d, {1'b0, bad, 32'h0});
        end else begin
            word = bad ? 32'h0 : (mdl_val[d][w] ? mdl_mem[d][w] : 32'hFFFF_FFFF);
            push(d, {1'b1, bad, word});
        end
        drive(d, wr, a, data, strb);
    endtask

    task automatic bus_idle(input int d);
        @(posedge clk); #1;
        psel_s[d]    = 1'b0;
        penable_s[d] = 1'b0;
    endtask

    task automatic random_traffic(input int d, input int n);
        logic [31:0] a;
        int          r;
        for (int i = 0; i < n; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
            else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else             a = 32'h400 + (32'($urandom_range(0, 63)) << 2);
            issue(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
        bus_idle(d);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; psel_s[d] = 1'b0; penable_s[d] = 1'b0; pwrite_s[d] = 1'b0;
            paddr_s[d] = '0; pwdata_s[d] = '0; pstrb_s[d] = '0; cyc[d] = 0;
            for (int w = 0; w < 256; w++) begin
                mdl_val[d][w] = 1'b0;
                mdl_mem[d][w] = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_outputs_dut%0d", d),
                  64'({pready_s[d], pslverr_s[d], prdata_s[d]}), 64'd0);
        end
        mon_on = 1'b1;

        // Zero-wait instance: fill reads, full and partial writes, errors.
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF);
        issue(0, 1'b0, 32'h04, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h04, 32'h0000_1122, 4'h3);
        issue(0, 1'b0, 32'h04, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h08, 32'h0000_00AA, 4'h1);
        issue(0, 1'b0, 32'h08, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h0C, 32'h1234_5678, 4'h0);
        issue(0, 1'b0, 32'h0C, 32'h0, 4'h0);
        issue(0, 1'b0, 32'h02, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h400, 32'h5555_5555, 4'hF);
        issue(0, 1'b0, 32'h00, 32'h0, 4'h0);
        issue(0, 1'b1, 32'h3FC, 32'hCAFE_F00D, 4'hF);
        issue(0, 1'b0, 32'h3FC, 32'h0, 4'h0);
        bus_idle(0);
        random_traffic(0, 80);

        // Three-wait instance: latency, abort, mid-transfer reset.
        issue(1, 1'b1, 32'h0C, 32'hA5A5_0F0F, 4'hF);
        issue(1, 1'b0, 32'h0C, 32'h0, 4'h0);
        bus_idle(1);

        @(posedge clk); #1;
        psel_s[1] = 1'b1; penable_s[1] = 1'b0; pwrite_s[1] = 1'b1;
        paddr_s[1] = 32'h20; pwdata_s[1] = 32'h1111_2222; pstrb_s[1] = 4'hF;
        @(posedge clk); #1;
        penable_s[1] = 1'b1;
        @(posedge clk); #1;
        psel_s[1] = 1'b0; penable_s[1] = 1'b0;
        repeat (6) @(posedge clk);
        issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
        issue(1, 1'b1, 32'h04, 32'h1234_5678, 4'hF);
        issue(1, 1'b0, 32'h04, 32'h0, 4'h0);
        bus_idle(1);

        @(posedge clk); #1;
        psel_s[1] = 1'b1; penable_s[1] = 1'b0; pwrite_s[1] = 1'b1;
        paddr_s[1] = 32'h08; pwdata_s[1] = 32'h7777_8888; pstrb_s[1] = 4'hF;
        @(posedge clk); #1;
        penable_s[1] = 1'b1;
        rst_s[1] = 1'b1;
        @(posedge clk); #1;
        rst_s[1] = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs_dut1",
              64'({pready_s[1], pslverr_s[1], prdata_s[1]}), 64'd0);
        @(posedge clk); #1;
        psel_s[1] = 1'b0; penable_s[1] = 1'b0;
        for (int w = 0; w < 256; w++) mdl_val[1][w] = 1'b0;
        issue(1, 1'b0, 32'h04, 32'h0, 4'h0);
        issue(1, 1'b0, 32'h08, 32'h0, 4'h0);
        bus_idle(1);
        random_traffic(1, 60);

        repeat (4) @(posedge clk);
        check("queue_drained_dut0", 64'(exp_q0.size()), 64'd0);
        check("queue_drained_dut1", 64'(exp_q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected run to finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
